// File: rtl/divider_sequential.sv
`default_nettype none
// ============================================================================
//  Module   : divider_sequential
//  Purpose  : Unsigned restoring shift-subtract divider. One quotient bit is
//             resolved per clock, MSB first, so a division takes
//             DIVIDEND_WIDTH cycles in RUN followed by a one-cycle DONE.
//
//  Ports    : clk            - single clock, rising edge
//             rst_n          - asynchronous active-low reset
//             start          - request a division (accepted in IDLE/DONE)
//             dividend       - unsigned dividend, latched on acceptance
//             divisor        - unsigned divisor, latched on acceptance
//             busy           - high while the iteration is running
//             done           - one-cycle pulse when results become valid
//             quotient       - unsigned quotient, held between operations
//             remainder      - unsigned remainder, held between operations
//             divide_by_zero - last accepted operation had divisor == 0
//
//  Options  : DIVIDER_ZERO_CHECK_EN - when defined, a zero divisor bypasses
//             the iteration, reports quotient all ones / remainder 0 and
//             raises divide_by_zero. When undefined, divide_by_zero is tied
//             low and a zero divisor runs the normal algorithm.
//
//  Revision : 1.0 - initial release
// ============================================================================
module divider_sequential #(
  parameter int DIVIDEND_WIDTH = 4,
  parameter int DIVISOR_WIDTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      divide_by_zero
);

  localparam int C_CNT_W = $clog2(DIVIDEND_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;

  // Dividend shift register: dividend bits leave at the MSB while quotient
  // bits enter at the LSB, so after the last iteration it holds the quotient.
  logic [DIVIDEND_WIDTH-1:0]   r_dvd;
  logic [DIVISOR_WIDTH-1:0]    r_divisor;
  logic [DIVISOR_WIDTH:0]      r_rem;
  logic [C_CNT_W-1:0]          r_count;
  logic [DIVIDEND_WIDTH-1:0]   r_quotient;
  logic [DIVISOR_WIDTH-1:0]    r_remainder;

  logic                        w_accept;
  logic                        w_last;
  logic                        w_zero_op;
  logic                        w_skip;
  logic [DIVISOR_WIDTH+1:0]    w_shift;
  logic                        w_qbit;
  logic [DIVISOR_WIDTH:0]      w_diff;
  logic [DIVISOR_WIDTH:0]      w_rem_next;

`ifdef DIVIDER_ZERO_CHECK_EN
  // r_zero marks a bypassed zero-divisor operation: it spends a single
  // cycle in RUN with busy suppressed, then reports the fixed result.
  logic r_zero;
  logic r_dbz;

  assign w_zero_op      = (divisor == '0);
  assign w_skip         = r_zero;
  assign divide_by_zero = r_dbz;
`else
  assign w_zero_op      = 1'b0;
  assign w_skip         = 1'b0;
  assign divide_by_zero = 1'b0;
`endif

  // One iteration: bring in the next dividend bit, trial-subtract, restore
  // on a negative result. The full previous remainder takes part in the
  // compare so that no bit of it is silently discarded.
  assign w_shift    = {r_rem, r_dvd[DIVIDEND_WIDTH-1]};
  assign w_qbit     = (w_shift >= {2'b00, r_divisor});
  assign w_diff     = w_shift[DIVISOR_WIDTH:0] - {1'b0, r_divisor};
  assign w_rem_next = w_qbit ? w_diff : w_shift[DIVISOR_WIDTH:0];
  assign w_last     = (r_count == C_CNT_W'(1));

  assign quotient   = r_quotient;
  assign remainder  = r_remainder;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = !w_skip;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath. Visible results are written only on the final iteration edge,
  // i.e. exactly on entry to DONE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd       <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
      r_zero      <= 1'b0;
      r_dbz       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_dvd     <= dividend;
      r_divisor <= divisor;
      r_rem     <= '0;
      r_count   <= w_zero_op ? C_CNT_W'(1) : C_CNT_W'(DIVIDEND_WIDTH);
`ifdef DIVIDER_ZERO_CHECK_EN
      r_zero    <= w_zero_op;
`endif
    end else if (r_state == S_RUN) begin
      r_dvd   <= {r_dvd[DIVIDEND_WIDTH-2:0], w_qbit};
      r_rem   <= w_rem_next;
      r_count <= r_count - C_CNT_W'(1);
      if (w_last) begin
`ifdef DIVIDER_ZERO_CHECK_EN
        if (r_zero) begin
          r_quotient  <= '1;
          r_remainder <= '0;
          r_dbz       <= 1'b1;
        end else begin
          r_quotient  <= {r_dvd[DIVIDEND_WIDTH-2:0], w_qbit};
          r_remainder <= w_rem_next[DIVISOR_WIDTH-1:0];
          r_dbz       <= 1'b0;
        end
`else
        r_quotient  <= {r_dvd[DIVIDEND_WIDTH-2:0], w_qbit};
        r_remainder <= w_rem_next[DIVISOR_WIDTH-1:0];
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_sequential.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divider_sequential
//  Purpose  : Self-checking bench for divider_sequential (default 4/2 sizing).
//             Expected results come from plain integer division and the
//             zero-divisor rules, with DIVIDER_ZERO_CHECK_EN honoured.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_divider_sequential;

  localparam int N  = 4;
  localparam int DW = 2;

`ifdef DIVIDER_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  dividend = '0;
  logic [DW-1:0] divisor = '0;
  logic          busy;
  logic          done;
  logic [N-1:0]  quotient;
  logic [DW-1:0] remainder;
  logic          divide_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Last reported result, used to confirm outputs hold while running.
  logic [N-1:0]  last_q = '0;
  logic [DW-1:0] last_r = '0;
  logic          last_z = 1'b0;

  divider_sequential #(
    .DIVIDEND_WIDTH (N),
    .DIVISOR_WIDTH  (DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .dividend       (dividend),
    .divisor        (divisor),
    .busy           (busy),
    .done           (done),
    .quotient       (quotient),
    .remainder      (remainder),
    .divide_by_zero (divide_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: ordinary integer division plus the zero-divisor rules.
  function automatic void model(input int a, input int b, output int q,
                                output int r, output int z, output int lat);
    if (b != 0) begin
      q = a / b; r = a % b; z = 0; lat = N;
    end else if (ZC) begin
      q = (1 << N) - 1; r = 0; z = 1; lat = 1;
    end else begin
      q = (1 << N) - 1; r = a % (1 << DW); z = 0; lat = N;
    end
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
    n_checks++;
    if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
    n_checks++;
    if (divide_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", divide_by_zero); end
    rst_n = 1'b1;
  endtask

  // Exhaustive sweep of every operand pair, then random pairs.
  task automatic test_divide(input int n_rand);
    int a, b, q, r, z, lat, cyc;
    logic [N-1:0]  eq;
    logic [DW-1:0] er;
    logic          ebusy;
    for (int i = 0; i < 64 + n_rand; i++) begin
      if (i < 64) begin
        a = i / 4; b = i % 4;
      end else begin
        a = int'($urandom_range(0, 15)); b = int'($urandom_range(0, 3));
      end
      model(a, b, q, r, z, lat);
      eq = q[N-1:0]; er = r[DW-1:0];
      ebusy = !(b == 0 && ZC);
      @(negedge clk);
      start = 1'b1; dividend = N'(a); divisor = DW'(b);
      @(negedge clk);
      start = 1'b0; dividend = N'($urandom); divisor = DW'($urandom);
      cyc = 0;
      while (done !== 1'b1 && cyc < 3 * N) begin
        n_checks++;
        if (busy !== ebusy || quotient !== last_q || remainder !== last_r ||
            divide_by_zero !== last_z) begin
          n_fail++;
          $display("FAIL run_%0d_%0d cycle %0d: busy %b q %0d r %0d z %b expected busy %b q %0d r %0d z %b",
                   a, b, cyc, busy, quotient, remainder, divide_by_zero, ebusy, last_q, last_r, last_z);
        end
        @(negedge clk);
        dividend = N'($urandom); divisor = DW'($urandom);
        cyc++;
      end
      n_checks++;
      if (cyc != lat) begin n_fail++; $display("FAIL latency_%0d_%0d: got %0d expected %0d", a, b, cyc, lat); end
      n_checks++;
      if (quotient !== eq || remainder !== er || divide_by_zero !== z[0] || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL result_%0d_%0d: got q %0d r %0d z %b busy %b expected q %0d r %0d z %0d busy 0",
                 a, b, quotient, remainder, divide_by_zero, busy, eq, er, z);
      end
      last_q = eq; last_r = er; last_z = z[0];
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_%0d_%0d: got %b expected 0", a, b, done); end
    end
  endtask

  // Start held high: 15/2 then 9/3 with no idle gap between them.
  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 2'd2;
    @(negedge clk);
    dividend = 4'd9; divisor = 2'd3;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy1: got %b expected 1", busy); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || quotient !== 4'd7 || remainder !== 2'd1) begin
      n_fail++;
      $display("FAIL b2b_first: got done %b q %0d r %0d expected done 1 q 7 r 1", done, quotient, remainder);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || quotient !== 4'd7) begin
      n_fail++;
      $display("FAIL b2b_second_start: got busy %b done %b q %0d expected busy 1 done 0 q 7", busy, done, quotient);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || quotient !== 4'd3 || remainder !== 2'd0) begin
      n_fail++;
      $display("FAIL b2b_second: got done %b q %0d r %0d expected done 1 q 3 r 0", done, quotient, remainder);
    end
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got done %b busy %b expected 0 0", done, busy);
    end
    last_q = 4'd3; last_r = 2'd0; last_z = 1'b0;
  endtask

  // A start pulse during RUN must not disturb the operation in flight.
  task automatic test_busy_ignore();
    int pulses;
    logic [N-1:0]  cq;
    logic [DW-1:0] cr;
    pulses = 0; cq = '0; cr = '0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd6; divisor = 2'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 2'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        pulses++; cq = quotient; cr = remainder;
      end
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
    n_checks++;
    if (cq !== 4'd6 || cr !== 2'd0) begin
      n_fail++;
      $display("FAIL ignore_result: got q %0d r %0d expected q 6 r 0", cq, cr);
    end
    last_q = 4'd6; last_r = 2'd0; last_z = 1'b0;
  endtask

  // Asynchronous reset two cycles into RUN, then a fresh 14/3.
  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 2'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || divide_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy %b done %b q %0d r %0d z %b expected all 0",
               busy, done, quotient, remainder, divide_by_zero);
    end
    start = 1'b1; dividend = 4'd14; divisor = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL in_reset_%0d: got done %b busy %b expected 0 0", i, done, busy);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL post_reset_accept: got busy %b expected 1", busy); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 3 * N) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != N || quotient !== 4'd4 || remainder !== 2'd2) begin
      n_fail++;
      $display("FAIL post_reset_result: got cycles %0d q %0d r %0d expected cycles %0d q 4 r 2",
               cyc, quotient, remainder, N);
    end
    @(negedge clk);
    last_q = 4'd4; last_r = 2'd2; last_z = 1'b0;
  endtask

  // 11 / 0 under whichever zero-divisor behaviour is built.
  task automatic test_divzero();
    int q, r, z, lat, cyc, busy_seen;
    model(11, 0, q, r, z, lat);
    @(negedge clk);
    start = 1'b1; dividend = 4'd11; divisor = 2'd0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; busy_seen = 0;
    while (done !== 1'b1 && cyc < 3 * N) begin
      if (busy === 1'b1) busy_seen++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != lat) begin n_fail++; $display("FAIL dz_latency: got %0d expected %0d", cyc, lat); end
    n_checks++;
    if (busy_seen != (ZC ? 0 : N)) begin
      n_fail++;
      $display("FAIL dz_busy_cycles: got %0d expected %0d", busy_seen, ZC ? 0 : N);
    end
    n_checks++;
    if (quotient !== q[N-1:0] || remainder !== r[DW-1:0] || divide_by_zero !== z[0]) begin
      n_fail++;
      $display("FAIL dz_result: got q %0d r %0d z %b expected q %0d r %0d z %0d",
               quotient, remainder, divide_by_zero, q, r, z);
    end
    @(negedge clk);
    last_q = q[N-1:0]; last_r = r[DW-1:0]; last_z = z[0];
  endtask

  initial begin
    test_reset();
    test_divide(24);
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_divzero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
